sng_stream_gen: RTL and testbench

Stochastic number generator stage that sits directly downstream of the free-running LFSR random source. Each cycle it compares the LFSR output against a latched operand and emits one bit of a unipolar stochastic bitstream, where P(bit=1) ≈ value/2^BITWIDTH. Streams have a programmable length, use a start/done handshake, and can be paused with hold. The generator also counts emitted ones so consumers and benches can check the encoded value.

---
 rtl/sng_stream_gen.sv | 105 ++++++++++
 tb/tb_sng_stream_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/sng_stream_gen.sv
// Unipolar stochastic bitstream generator: one bit per cycle (rand_in < value), first bit one cycle after start, done one cycle after the last bit.
// Backpressure: hold pauses emission and freezes all counters; start is only accepted while idle.
module sng_stream_gen #(
    parameter int BITWIDTH  = 10,
    parameter int LEN_WIDTH = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [BITWIDTH-1:0]  value,
    input  logic [LEN_WIDTH-1:0] stream_len,
    input  logic                 hold,
    input  logic [BITWIDTH-1:0]  rand_in,
    output logic                 busy,
    output logic                 bit_out,
    output logic                 bit_valid,
    output logic [LEN_WIDTH-1:0] ones_cnt,
    output logic                 done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

    state_t               state;
    state_t               state_nxt;
    logic [BITWIDTH-1:0]  value_q;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 hit;

    assign hit  = (rand_in < value_q);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (stream_len == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // remaining <= 1 also covers the unreachable 0 case so RUN can never stall
                if (!hold && (remaining <= LEN_ONE)) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value_q   <= '0;
            remaining <= '0;
            ones_cnt  <= '0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    bit_valid <= 1'b0;
                    if (start) begin
                        value_q   <= value;
                        remaining <= stream_len;
                        ones_cnt  <= '0;
                    end
                end
                S_RUN: begin
                    if (hold) begin
                        bit_valid <= 1'b0;
                    end else begin
                        bit_out   <= hit;
                        bit_valid <= 1'b1;
                        ones_cnt  <= ones_cnt + LEN_WIDTH'(hit);
                        if (remaining != '0) begin
                            remaining <= remaining - LEN_ONE;
                        end
                    end
                end
                S_DONE: begin
                    bit_valid <= 1'b0;
                    done      <= 1'b1;
                end
                default: bit_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_sng_stream_gen.sv
// Randomized bench for sng_stream_gen against a stream-level model of emitted bits, ones count and done timing.
module tb_sng_stream_gen;

    logic        clk;
    logic        rst;
    logic        start;
    logic [9:0]  value;
    logic [10:0] stream_len;
    logic        hold;
    logic [9:0]  rand_in;
    logic        busy;
    logic        bit_out;
    logic        bit_valid;
    logic [10:0] ones_cnt;
    logic        done;

    int n_chk  = 0;
    int n_pass = 0;

    logic [9:0] rq[$];
    bit         hq[$];
    bit         last_bit;

    sng_stream_gen #(.BITWIDTH(10), .LEN_WIDTH(11)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .value      (value),
        .stream_len (stream_len),
        .hold       (hold),
        .rand_in    (rand_in),
        .busy       (busy),
        .bit_out    (bit_out),
        .bit_valid  (bit_valid),
        .ones_cnt   (ones_cnt),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    endtask

    // One whole stream; per-cycle rand/hold come from rq/hq when queued, otherwise random.
    task automatic run_stream(input logic [9:0] v, input logic [10:0] n,
                              input int hold_pct, input bit noisy_start);
        int         bits;
        int         ones;
        logic [9:0] r;
        bit         h;
        bit         exp_b;
        @(negedge clk);
        start = 1'b1; value = v; stream_len = n; hold = 1'b0; rand_in = 10'($urandom);
        @(posedge clk); #1;
        check("busy_after_start", busy, 1);
        check("ones_cleared", ones_cnt, 0);
        check("no_bit_at_start", bit_valid, 0);
        bits = 0;
        ones = 0;
        while (bits < int'(n)) begin
            @(negedge clk);
            r = (rq.size() != 0) ? rq.pop_front() : 10'($urandom);
            h = (hq.size() != 0) ? hq.pop_front() : ($urandom_range(99) < hold_pct);
            rand_in = r;
            hold = h;
            start = noisy_start ? 1'($urandom) : 1'b0;
            value = 10'($urandom);
            stream_len = 11'($urandom);
            @(posedge clk); #1;
            if (h) begin
                check("hold_no_valid", bit_valid, 0);
                check("hold_bit_kept", bit_out, last_bit);
            end else begin
                exp_b = (r < v);
                bits++;
                ones += int'(exp_b);
                last_bit = exp_b;
                check("bit_valid", bit_valid, 1);
                check("bit_out", bit_out, exp_b);
            end
            check("ones_running", ones_cnt, ones);
            check("no_early_done", done, 0);
            check("busy_run", busy, 1);
        end
        @(negedge clk);
        hold = 1'($urandom);
        start = noisy_start ? 1'($urandom) : 1'b0;
        rand_in = 10'($urandom);
        @(posedge clk); #1;
        check("done_pulse", done, 1);
        check("done_no_valid", bit_valid, 0);
        check("idle_after_done", busy, 0);
        check("ones_final", ones_cnt, ones);
        @(negedge clk);
        start = 1'b0; hold = 1'b0;
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
        check("ones_held", ones_cnt, ones);
    endtask

    initial begin
        logic [9:0] lfsr;
        logic [9:0] tap;
        rst = 1'b1; start = 1'b0; value = '0; stream_len = '0; hold = 1'b0; rand_in = '0;
        last_bit = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_bit_out", bit_out, 0);
        check("rst_bit_valid", bit_valid, 0);
        check("rst_ones", ones_cnt, 0);
        check("rst_done", done, 0);
        @(negedge clk); rst = 1'b0;

        // value=0 against a 10-bit LFSR source
        tap = 10'b0100010001;
        lfsr = 10'd1;
        for (int i = 0; i < 16; i++) begin
            rq.push_back(lfsr);
            lfsr = {lfsr[8:0], ^(lfsr & tap)};
        end
        run_stream(10'd0, 11'd16, 0, 1'b0);

        // max value: only an all-ones rand word yields 0
        rq = '{10'd5, 10'd5, 10'd1023, 10'd5, 10'd5, 10'd5, 10'd5, 10'd5};
        run_stream(10'd1023, 11'd8, 0, 1'b0);

        // compare threshold around the operand, starts during RUN ignored
        rq = '{10'd100, 10'd600, 10'd511, 10'd512};
        run_stream(10'd512, 11'd4, 0, 1'b1);

        // 3-cycle hold after the 2nd bit
        hq = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        run_stream(10'($urandom), 11'd5, 0, 1'b0);

        // zero-length stream
        run_stream(10'($urandom), 11'd0, 0, 1'b0);

        // rand_in=0 with a nonzero operand
        rq = '{10'd0, 10'd0};
        run_stream(10'd1, 11'd2, 0, 1'b0);

        // reset in the middle of a 16-bit stream
        @(negedge clk);
        start = 1'b1; value = 10'd700; stream_len = 11'd16; rand_in = 10'($urandom);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", busy, 0);
        check("abort_bit_out", bit_out, 0);
        check("abort_bit_valid", bit_valid, 0);
        check("abort_ones", ones_cnt, 0);
        check("abort_done", done, 0);
        last_bit = 1'b0;
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", done, 0);
            check("abort_stays_idle", busy, 0);
        end
        run_stream(10'($urandom), 11'd16, 0, 1'b0);

        // random streams with random holds and noisy starts
        for (int i = 0; i < 25; i++) begin
            run_stream(10'($urandom), 11'($urandom_range(40)), 25, 1'b1);
        end

        // maximum stream length
        run_stream(10'($urandom), 11'd2047, 10, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
